sync_fifo: RTL
==============

# sync_fifo

Parametrised single-clock FIFO; next generation of the team's pointer-based FIFO for same-clock producer/consumer paths. Adds exact occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush and non-power-of-two depth. Output mode is registered read (default) or first-word-fall-through, selected at compile time.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries (≥2; any integer, power of two not required)
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous and active-high
- clear  in  1  synchronous flush
- push  in  1  write request
- datain  in  WIDTH  write data
- pop  in  1  read request
- dataout  out  WIDTH  read data
- dataout_valid  out  1  dataout holds a valid word (see Operation)
- full, empty  out  1  occupancy == DEPTH / == 0
- almost_full, almost_empty  out  1  threshold flags
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow, underflow  out  1  sticky error flags

## Operation
- Reset values: count 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0, dataout 0, dataout_valid 0; pointers 0. Memory not reset.
- Index width AWIDTH = $clog2(DEPTH); write/read indices wrap DEPTH-1 → 0 (explicit compare, not natural overflow).
- Push accepted iff push && !full; writes datain at write index, increments it.
- Pop accepted iff pop && !empty; increments read index.
- Acceptance uses flag values at the start of the cycle. Full with push+pop: pop accepted, push rejected. Empty with push+pop: push accepted, pop rejected.
- count next = count + accepted_push − accepted_pop; all flags registered, derived from next count, so they change on the same edge as count.
- Rejected push sets overflow; rejected pop sets underflow; both held until rst or clear.
- clear: pointers, count, flags, error flags, dataout_valid to reset values on next edge; push/pop in the same cycle ignored; dataout holds last value in registered mode.

## Timing
- Push → count/empty update: 1 cycle (word visible to read side the edge after write).
- Registered mode: accepted pop at edge N loads head word into dataout at edge N; dataout_valid high for exactly the following cycle per accepted pop; dataout holds otherwise.
- FWFT mode: dataout = head word combinationally from memory whenever empty == 0; dataout_valid = !empty; pop consumes current word.
- Back-to-back push or pop every cycle sustained at full rate; no bubbles.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through output as above, no output register.
- Undefined: registered read, 1-cycle pop-to-data latency, dataout_valid pulse.
- Flags, count and error behaviour identical in both modes.

## Structure
- Package fifo_pkg: default WIDTH/DEPTH constants and a count-width function (clog2(DEPTH)+1) shared with other FIFO blocks.
- Sub-module fifo_ptr: wrap-around index counter (parameter DEPTH; inputs clk, rst, clear, inc; output idx), instantiated for write and read indices.
- Memory and flag logic in sync_fifo top.

## Test plan
- Reset mid-stream with count 5 → all outputs at reset values same cycle rst rises, count 0, empty 1.
- DEPTH=5 (non-power-of-two), push 0x01..0x05 → full 1, count 5; pop 5 → 0x01..0x05 in order, empty 1; repeat 3 passes to exercise wrap.
- Push at full (count 16) → word dropped, overflow 1 sticky; push+pop at full → count 15, overflow stays 1.
- Pop at empty → underflow 1; push+pop at empty → count 1, no data out; clear → count 0, overflow/underflow 0.
- AF_THRESH=14, AE_THRESH=2: fill 0→16 → almost_empty drops at count 3, almost_full rises at count 14, each on the count-update edge.
- Both modes: push 0xA5 then pop → registered: dataout 0xA5 with dataout_valid one cycle after pop; FWFT: 0xA5 on dataout one cycle after push, before pop.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the FIFO family.
//   FIFO_DEFAULT_WIDTH / FIFO_DEFAULT_DEPTH : default word width and depth
//   PTR_WR / PTR_RD / NUM_PTRS              : slots in the index-counter array
//   fifo_count_width(depth)                 : bits needed to hold 0..depth
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DEFAULT_WIDTH = 8;
  localparam int FIFO_DEFAULT_DEPTH = 16;

  // Slot assignment for the write/read index counters built in a generate loop.
  localparam int PTR_WR   = 0;
  localparam int PTR_RD   = 1;
  localparam int NUM_PTRS = 2;

  // An occupancy counter must represent DEPTH itself, so it needs one bit
  // more than the index width.
  function automatic int fifo_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
// Wrap-around index counter for a FIFO of arbitrary (non power-of-two) depth.
// Counts 0..DEPTH-1 and wraps to 0 by explicit compare.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, index -> 0
//   clear : synchronous reset of the index to 0 (wins over inc)
//   inc   : advance the index by one
//   idx   : current index, $clog2(DEPTH) bits
// -----------------------------------------------------------------------------
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int  DEPTH  = FIFO_DEFAULT_DEPTH,
  localparam int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  output logic [AWIDTH-1:0] idx
);

  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

  logic [AWIDTH-1:0] idx_reg;
  logic [AWIDTH-1:0] idx_next;

  always_comb begin
    idx_next = idx_reg;
    if (clear) begin
      idx_next = '0;
    end else if (inc) begin
      // Natural binary overflow only matches DEPTH for powers of two.
      idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= '0;
    end else begin
      idx_reg <= idx_next;
    end
  end

  assign idx = idx_reg;

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with exact occupancy, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags, synchronous flush and any depth.
//
// Output mode (compile time):
//   SYNC_FIFO_FWFT_EN undefined : registered read. An accepted pop loads the
//                                 head word into dataout on that edge and
//                                 dataout_valid pulses for the next cycle.
//   SYNC_FIFO_FWFT_EN defined   : first-word-fall-through. dataout shows the
//                                 head word whenever not empty,
//                                 dataout_valid = !empty.
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   clear             : synchronous flush (push/pop ignored that cycle)
//   push, datain      : write request and data
//   pop               : read request
//   dataout           : read data
//   dataout_valid     : dataout holds a valid word
//   full, empty       : occupancy == DEPTH / == 0
//   almost_full       : count >= AF_THRESH
//   almost_empty      : count <= AE_THRESH
//   count             : occupancy 0..DEPTH
//   overflow          : sticky, push attempted while full
//   underflow         : sticky, pop attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int  WIDTH     = FIFO_DEFAULT_WIDTH,
  parameter int  DEPTH     = FIFO_DEFAULT_DEPTH,
  parameter int  AF_THRESH = DEPTH - 2,
  parameter int  AE_THRESH = 2,
  localparam int AWIDTH    = $clog2(DEPTH),
  localparam int CWIDTH    = fifo_count_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [WIDTH-1:0]  datain,
  input  logic              pop,
  output logic [WIDTH-1:0]  dataout,
  output logic              dataout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CWIDTH-1:0] count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [CWIDTH-1:0] COUNT_FULL = CWIDTH'(DEPTH);
  localparam logic [CWIDTH-1:0] AF_LEVEL   = CWIDTH'(AF_THRESH);
  localparam logic [CWIDTH-1:0] AE_LEVEL   = CWIDTH'(AE_THRESH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]  mem [DEPTH];

  logic [CWIDTH-1:0] count_reg;
  logic [CWIDTH-1:0] count_next;
  logic              full_reg;
  logic              empty_reg;
  logic              almost_full_reg;
  logic              almost_empty_reg;
  logic              overflow_reg;
  logic              overflow_next;
  logic              underflow_reg;
  logic              underflow_next;

  logic              push_acc;
  logic              pop_acc;

  logic [NUM_PTRS-1:0] ptr_inc;
  logic [AWIDTH-1:0]   ptr_idx [NUM_PTRS];
  logic [AWIDTH-1:0]   wr_idx;
  logic [AWIDTH-1:0]   rd_idx;

  // ---------------------------------------------------------------------------
  // Acceptance uses the registered flags from the start of the cycle, so a
  // simultaneous push+pop at full keeps the pop and drops the push (and vice
  // versa at empty). A flush swallows both requests.
  // ---------------------------------------------------------------------------
  assign push_acc = push && !full_reg  && !clear;
  assign pop_acc  = pop  && !empty_reg && !clear;

  // ---------------------------------------------------------------------------
  // Write and read index counters
  // ---------------------------------------------------------------------------
  assign ptr_inc[PTR_WR] = push_acc;
  assign ptr_inc[PTR_RD] = pop_acc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PTRS; gi++) begin : g_ptr
      fifo_ptr #(
        .DEPTH (DEPTH)
      ) u_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (ptr_inc[gi]),
        .idx   (ptr_idx[gi])
      );
    end
  endgenerate

  assign wr_idx = ptr_idx[PTR_WR];
  assign rd_idx = ptr_idx[PTR_RD];

  // ---------------------------------------------------------------------------
  // Storage (not reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_idx] <= datain;
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy and error flags
  // ---------------------------------------------------------------------------
  always_comb begin
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (clear) begin
      count_next     = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      if (push_acc && !pop_acc) begin
        count_next = count_reg + 1'b1;
      end else if (!push_acc && pop_acc) begin
        count_next = count_reg - 1'b1;
      end
      if (push && full_reg) begin
        overflow_next = 1'b1;
      end
      if (pop && empty_reg) begin
        underflow_next = 1'b1;
      end
    end
  end

  // All status flags are registered from count_next so they move on the same
  // edge as count itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      count_reg        <= count_next;
      full_reg         <= (count_next == COUNT_FULL);
      empty_reg        <= (count_next == '0);
      almost_full_reg  <= (count_next >= AF_LEVEL);
      almost_empty_reg <= (count_next <= AE_LEVEL);
      overflow_reg     <= overflow_next;
      underflow_reg    <= underflow_next;
    end
  end

  assign count        = count_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
`ifdef SYNC_FIFO_FWFT_EN
  // Head word straight from the array; forced to zero while empty so the
  // unwritten (unreset) storage never shows on the port.
  assign dataout       = empty_reg ? '0 : mem[rd_idx];
  assign dataout_valid = !empty_reg;
`else
  logic [WIDTH-1:0] dataout_reg;
  logic             dataout_valid_reg;

  // Registered read: the word is captured on the pop edge and then held, so
  // a flush leaves the last delivered word on the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataout_reg       <= '0;
      dataout_valid_reg <= 1'b0;
    end else begin
      dataout_valid_reg <= pop_acc;
      if (pop_acc) begin
        dataout_reg <= mem[rd_idx];
      end
    end
  end

  assign dataout       = dataout_reg;
  assign dataout_valid = dataout_valid_reg;
`endif

endmodule
